instr_encoder_loader: RTL and testbench



---
 rtl/instr_encoder_loader.sv | 164 ++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic ADD/SUB/AND/OR/NOR/SLT/ADDI instructions into MIPS words
// and streams them into consecutive instruction-memory addresses.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic              last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count,
  output logic [2:0]        dbg_state
);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready is a pure function of state and never looks at in_valid.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP_PTR  = {ADDR_W{1'b1}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [ADDR_W:0]     count_q, count_d;

  logic [5:0]          funct;
  logic                is_addi;
  logic                illegal;
  logic [31:0]         enc_word;

  always_comb begin
    funct   = 6'b100000;
    is_addi = 1'b0;
    illegal = 1'b0;
    case (op_sel)
      3'b000:  funct = 6'b100000;
      3'b001:  funct = 6'b100010;
      3'b010:  funct = 6'b100100;
      3'b011:  funct = 6'b100101;
      3'b100:  funct = 6'b100111;
      3'b101:  funct = 6'b101010;
      3'b110:  is_addi = 1'b1;
      default: illegal = 1'b1;
    endcase
    enc_word = is_addi ? {6'b001000, rs, rt, imm}
                       : {6'b000000, rs, rt, rd, 5'b00000, funct};
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    last_d     = last_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    count_d    = count_q;
    if (start) begin
      // A write in flight still pulses mem_we this cycle but is not counted.
      state_d    = S_ACCEPT;
      ptr_d      = BASE_PTR;
      count_d    = '0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = 2'b00;
    end else begin
      case (state_q)
        S_ACCEPT: begin
          if (in_valid) begin
            if (illegal) begin
              state_d    = S_ERR;
              err_d      = 1'b1;
              err_code_d = 2'b01;
            end else begin
              state_d = S_WRITE;
              addr_d  = ptr_q;
              wdata_d = enc_word;
              last_d  = last;
            end
          end
        end
        S_WRITE: begin
          count_d = count_q + 1'b1;
          ptr_d   = ptr_q + 1'b1;
          if (last_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (ptr_q == TOP_PTR) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = 2'b10;
          end else begin
            state_d = S_ACCEPT;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      count_q    <= count_d;
    end
  end

  assign in_ready  = (state_q == S_ACCEPT);
  assign mem_we    = (state_q == S_WRITE);
  assign busy      = (state_q == S_ACCEPT) || (state_q == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign count     = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: an ADDR_W=8 instance for the main
// program flows and an ADDR_W=2 instance for the memory-full boundary.
module tb_instr_encoder_loader;

  localparam int AW_A = 8;
  localparam int AW_B = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, in_valid, last;
  logic [2:0]  op_sel;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  logic            a_in_ready, a_mem_we, a_busy, a_done, a_err;
  logic [AW_A-1:0] a_mem_addr;
  logic [31:0]     a_mem_wdata;
  logic [1:0]      a_err_code;
  logic [AW_A:0]   a_count;
  logic [2:0]      a_dbg_state;

  logic            b_in_ready, b_mem_we, b_busy, b_done, b_err;
  logic [AW_B-1:0] b_mem_addr;
  logic [31:0]     b_mem_wdata;
  logic [1:0]      b_err_code;
  logic [AW_B:0]   b_count;
  logic [2:0]      b_dbg_state;

  instr_encoder_loader #(.ADDR_W(AW_A), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(a_in_ready), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .last(last), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .busy(a_busy), .done(a_done), .err(a_err),
    .err_code(a_err_code), .count(a_count), .dbg_state(a_dbg_state)
  );

  instr_encoder_loader #(.ADDR_W(AW_B), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(b_in_ready), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .last(last), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .busy(b_busy), .done(b_done), .err(b_err),
    .err_code(b_err_code), .count(b_count), .dbg_state(b_dbg_state)
  );

  // scoreboard: expected writes vs. writes seen on the memory port
  logic [39:0] exp_a_q[$];
  logic [39:0] exp_b_q[$];
  logic [39:0] got_a_q[$];
  logic [39:0] got_b_q[$];
  int n_pass  = 0;
  int n_total = 0;

  always @(negedge clk) begin
    if (a_mem_we) got_a_q.push_back({a_mem_addr, a_mem_wdata});
    if (b_mem_we) got_b_q.push_back({6'd0, b_mem_addr, b_mem_wdata});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input bit use_b, input logic [2:0] op, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] d,
                      input logic [15:0] im, input logic lst);
    int n = 0;
    op_sel = op; rs = s; rt = t; rd = d; imm = im; last = lst;
    in_valid = 1'b1;
    while (!(use_b ? b_in_ready : a_in_ready) && n < 20) begin
      step();
      n++;
    end
    chk("hs_ready", use_b ? b_in_ready : a_in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    last = 1'b0;
  endtask

  task automatic expw(input bit use_b, input logic [7:0] addr, input logic [31:0] w);
    if (use_b) exp_b_q.push_back({addr, w});
    else exp_a_q.push_back({addr, w});
  endtask

  task automatic clear_sb();
    exp_a_q.delete(); exp_b_q.delete(); got_a_q.delete(); got_b_q.delete();
  endtask

  task automatic check_writes(input bit use_b);
    logic [39:0] g, e;
    if (use_b) begin
      chk("b_nwrites", got_b_q.size(), exp_b_q.size());
      while (got_b_q.size() > 0 && exp_b_q.size() > 0) begin
        g = got_b_q.pop_front(); e = exp_b_q.pop_front();
        chk("b_write", g, e);
      end
    end else begin
      chk("a_nwrites", got_a_q.size(), exp_a_q.size());
      while (got_a_q.size() > 0 && exp_a_q.size() > 0) begin
        g = got_a_q.pop_front(); e = exp_a_q.pop_front();
        chk("a_write", g, e);
      end
    end
    clear_sb();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; last = 1'b0;
    op_sel = 3'b000; rs = '0; rt = '0; rd = '0; imm = '0;
    repeat (3) step();
    chk("rst_in_ready", a_in_ready, 1'b0);
    chk("rst_mem_we", a_mem_we, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_count", a_count, 9'd0);
    chk("rst_wdata", a_mem_wdata, 32'd0);
    chk("rst_b_count", b_count, 3'd0);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", a_in_ready, 1'b0);
    clear_sb();

    // single ADD
    do_start();
    chk("t1_in_ready", a_in_ready, 1'b1);
    chk("t1_busy", a_busy, 1'b1);
    send(0, 3'b000, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    expw(0, 8'd0, 32'h00221820);
    chk("t1_we", a_mem_we, 1'b1);
    chk("t1_addr", a_mem_addr, 8'd0);
    chk("t1_wdata", a_mem_wdata, 32'h00221820);
    chk("t1_ready_in_write", a_in_ready, 1'b0);
    step();
    chk("t1_we_off", a_mem_we, 1'b0);
    chk("t1_count", a_count, 9'd1);
    chk("t1_ready_back", a_in_ready, 1'b1);
    check_writes(0);

    // back-to-back program ending with ADDI last
    do_start();
    send(0, 3'b001, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    send(0, 3'b100, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    send(0, 3'b101, 5'd4, 5'd5, 5'd6, 16'd0, 1'b0);
    send(0, 3'b110, 5'd0, 5'd8, 5'd31, 16'd5, 1'b1);
    expw(0, 8'd0, 32'h00221822);
    expw(0, 8'd1, 32'h00221827);
    expw(0, 8'd2, 32'h0085302A);
    expw(0, 8'd3, 32'h20080005);
    step();
    chk("t2_done", a_done, 1'b1);
    chk("t2_err", a_err, 1'b0);
    chk("t2_count", a_count, 9'd4);
    chk("t2_in_ready", a_in_ready, 1'b0);
    chk("t2_busy", a_busy, 1'b0);
    chk("t2_addr_hold", a_mem_addr, 8'd3);
    step();
    chk("t2_done_held", a_done, 1'b1);
    check_writes(0);

    // illegal op after one legal word
    do_start();
    chk("t3_done_cleared", a_done, 1'b0);
    send(0, 3'b011, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    expw(0, 8'd0, 32'h00221825);
    send(0, 3'b111, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    chk("t3_no_we", a_mem_we, 1'b0);
    step();
    chk("t3_err", a_err, 1'b1);
    chk("t3_err_code", a_err_code, 2'b01);
    chk("t3_count", a_count, 9'd1);
    chk("t3_in_ready", a_in_ready, 1'b0);
    check_writes(0);
    do_start();
    chk("t3_err_clr", a_err, 1'b0);
    chk("t3_code_clr", a_err_code, 2'b00);
    chk("t3_count_clr", a_count, 9'd0);
    send(0, 3'b000, 5'd7, 5'd7, 5'd7, 16'd0, 1'b0);
    expw(0, 8'd0, 32'h00E73820);
    chk("t3_restart_addr", a_mem_addr, 8'd0);
    step();

    // idle source: ACCEPT holds with no writes
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_ready", a_in_ready, 1'b1);
      chk("t6_no_we", a_mem_we, 1'b0);
    end
    chk("t6_count", a_count, 9'd1);
    check_writes(0);

    // ADDR_W=2: fill without last -> overflow
    do_start();
    send(1, 3'b010, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    send(1, 3'b011, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    send(1, 3'b000, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    send(1, 3'b001, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    expw(1, 8'd0, 32'h00221824);
    expw(1, 8'd1, 32'h00221825);
    expw(1, 8'd2, 32'h00221820);
    expw(1, 8'd3, 32'h00221822);
    step();
    chk("t4_err", b_err, 1'b1);
    chk("t4_err_code", b_err_code, 2'b10);
    chk("t4_count", b_count, 3'd4);
    chk("t4_done", b_done, 1'b0);
    chk("t4_ready", b_in_ready, 1'b0);
    check_writes(1);

    // ADDR_W=2: last on the 4th word wins over full
    do_start();
    send(1, 3'b010, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    send(1, 3'b011, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    send(1, 3'b000, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    send(1, 3'b001, 5'd1, 5'd2, 5'd3, 16'd0, 1'b1);
    expw(1, 8'd0, 32'h00221824);
    expw(1, 8'd1, 32'h00221825);
    expw(1, 8'd2, 32'h00221820);
    expw(1, 8'd3, 32'h00221822);
    step();
    chk("t4b_done", b_done, 1'b1);
    chk("t4b_err", b_err, 1'b0);
    chk("t4b_err_code", b_err_code, 2'b00);
    chk("t4b_count", b_count, 3'd4);
    check_writes(1);

    // reset (with start) during WRITE
    do_start();
    clear_sb();
    send(0, 3'b000, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    expw(0, 8'd0, 32'h00221820);
    rst_n = 1'b0;
    start = 1'b1;
    step();
    rst_n = 1'b1;
    start = 1'b0;
    chk("t5_we", a_mem_we, 1'b0);
    chk("t5_ready", a_in_ready, 1'b0);
    chk("t5_addr", a_mem_addr, 8'd0);
    chk("t5_wdata", a_mem_wdata, 32'd0);
    chk("t5_busy", a_busy, 1'b0);
    chk("t5_done", a_done, 1'b0);
    chk("t5_err", a_err, 1'b0);
    chk("t5_err_code", a_err_code, 2'b00);
    chk("t5_count", a_count, 9'd0);
    repeat (3) step();
    chk("t5_idle_ready", a_in_ready, 1'b0);
    check_writes(0);

    // start during DONE, then start during WRITE (write not counted)
    do_start();
    send(0, 3'b000, 5'd1, 5'd2, 5'd3, 16'd0, 1'b1);
    expw(0, 8'd0, 32'h00221820);
    step();
    chk("t5_done_set", a_done, 1'b1);
    do_start();
    chk("t5_done_clr", a_done, 1'b0);
    chk("t5_restart_ready", a_in_ready, 1'b1);
    send(0, 3'b011, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    expw(0, 8'd0, 32'h00221825);
    chk("t5_restart_addr", a_mem_addr, 8'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_wr_uncounted", a_count, 9'd0);
    chk("t5_wr_ready", a_in_ready, 1'b1);
    send(0, 3'b100, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0);
    expw(0, 8'd0, 32'h00221827);
    step();
    chk("t5_count_after", a_count, 9'd1);
    check_writes(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
